// File: rtl/serial_addsub_if.sv
// Operand/result bundle between an arithmetic controller and serial_adder_subtractor.
// The controller is the master; the arithmetic unit is the slave.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             M;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             V;
  logic             Z;

  modport master (output start, A, B, M, input busy, done, S, C, V, Z);
  modport slave  (input start, A, B, M, output busy, done, S, C, V, Z);
endinterface

// File: rtl/serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, K+1 cycles per operation.
// Optional saturation on signed overflow is enabled by defining SERIAL_ADDSUB_SAT_EN.
module serial_adder_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [WIDTH-1:0] SIGNED_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, part_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last_digit, load, finish;

  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] sum_digit;
  logic [WIDTH-1:0] result, final_s;
  logic             overflow;

`ifdef SERIAL_ADDSUB_SAT_EN
  logic a_msb_q;
`endif

  assign last_digit = (cnt_q == CW'(K - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_digit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    load     = (state_q == IDLE) && bus.start;
    finish   = (state_q == RUN) && last_digit;
  end

  // Ripple chain across one digit; chain[DIGIT-1] is the carry into the digit's top bit.
  always_comb begin
    chain     = '0;
    sum_digit = '0;
    chain[0]  = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      sum_digit[i] = a_q[i] ^ b_q[i] ^ chain[i];
      chain[i+1]   = (a_q[i] & b_q[i]) | (chain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  assign result   = (part_q >> DIGIT) | (WIDTH'(sum_digit) << (WIDTH - DIGIT));
  assign overflow = chain[DIGIT] ^ chain[DIGIT-1];

  always_comb begin
    final_s = result;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (overflow) final_s = a_msb_q ? SIGNED_MIN : ~SIGNED_MIN;
`endif
  end

  // NOTE: the operand registers are reset as well, so nothing in the datapath powers up undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
      a_msb_q <= 1'b0;
`endif
    end else if (load) begin
      a_q     <= bus.A;
      b_q     <= bus.B ^ {WIDTH{bus.M}};
      part_q  <= '0;
      carry_q <= bus.M;
      cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
      a_msb_q <= bus.A[WIDTH-1];
`endif
    end else if (state_q == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      part_q  <= result;
      carry_q <= chain[DIGIT];
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Result flags change only on completion, never mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done <= 1'b0;
      bus.S    <= '0;
      bus.C    <= 1'b0;
      bus.V    <= 1'b0;
      bus.Z    <= 1'b0;
    end else begin
      bus.done <= finish;
      if (finish) begin
        bus.S <= final_s;
        bus.C <= chain[DIGIT];
        bus.V <= overflow;
        bus.Z <= (final_s == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Bench for serial_adder_subtractor: a WIDTH=4/DIGIT=1 instance and a WIDTH=8/DIGIT=2 instance,
// checked with a vector table, hand-written timing sequences and random operands against an integer model.
module tb_serial_adder_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(4)) bus4 ();
  serial_addsub_if #(.WIDTH(8)) bus8 ();

  serial_adder_subtractor #(.WIDTH(4), .DIGIT(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  serial_adder_subtractor #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Integer reference: true signed/unsigned arithmetic, no bit-level carries.
  function automatic void model(input int w, input longint a, input longint b, input bit m,
                                output longint s, output bit c, output bit v, output bit z);
    longint one  = 1;
    longint full = one << w;
    longint half = one << (w - 1);
    longint usum, sa, sb, res;
    usum = m ? (a - b + full) : (a + b);
    s    = usum % full;
    c    = (usum >= full);
    sa   = (a >= half) ? a - full : a;
    sb   = (b >= half) ? b - full : b;
    res  = m ? sa - sb : sa + sb;
    v    = (res >= half) || (res < -half);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (v) s = (sa < 0) ? half : half - 1;
`endif
    z    = (s == 0);
  endfunction

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic m,
                     output logic [3:0] s, output logic c, output logic v, output logic z);
    logic [3:0] s_prev;
    int lat;
    s_prev = bus4.S;
    bus4.A = a; bus4.B = b; bus4.M = m; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    check("busy_after_start4", bus4.busy, 1);
    lat = -1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (bus4.done) begin lat = n; break; end
      check("S_hold_mid_op4", bus4.S, s_prev);
    end
    check("latency4", lat, 4);
    check("busy_at_done4", bus4.busy, 0);
    s = bus4.S; c = bus4.C; v = bus4.V; z = bus4.Z;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m,
                     output logic [7:0] s, output logic c, output logic v, output logic z);
    logic [7:0] s_prev;
    int lat;
    s_prev = bus8.S;
    bus8.A = a; bus8.B = b; bus8.M = m; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    check("busy_after_start8", bus8.busy, 1);
    lat = -1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (bus8.done) begin lat = n; break; end
      check("S_hold_mid_op8", bus8.S, s_prev);
    end
    check("latency8", lat, 4);
    check("busy_at_done8", bus8.busy, 0);
    s = bus8.S; c = bus8.C; v = bus8.V; z = bus8.Z;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [3:0] s;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [3:0] s4;
    logic [7:0] s8, ra, rb;
    logic       c, v, z, rm;
    longint     es;
    bit         ec, ev, ez;

    vecs[0] = '{a: 4'd3,  b: 4'd2, m: 1'b0, s: 4'd5,  c: 1'b0, v: 1'b0, z: 1'b0};
    vecs[1] = '{a: 4'd2,  b: 4'd2, m: 1'b1, s: 4'd0,  c: 1'b1, v: 1'b0, z: 1'b1};
    vecs[2] = '{a: 4'd3,  b: 4'd4, m: 1'b1, s: 4'd15, c: 1'b0, v: 1'b0, z: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd1, m: 1'b0, s: 4'd0,  c: 1'b1, v: 1'b0, z: 1'b1};
`ifdef SERIAL_ADDSUB_SAT_EN
    vecs[3] = '{a: 4'd7,  b: 4'd1, m: 1'b0, s: 4'd7,  c: 1'b0, v: 1'b1, z: 1'b0};
    vecs[5] = '{a: 4'd8,  b: 4'd8, m: 1'b0, s: 4'd8,  c: 1'b1, v: 1'b1, z: 1'b0};
    vecs[6] = '{a: 4'd0,  b: 4'd8, m: 1'b1, s: 4'd7,  c: 1'b0, v: 1'b1, z: 1'b0};
`else
    vecs[3] = '{a: 4'd7,  b: 4'd1, m: 1'b0, s: 4'd8,  c: 1'b0, v: 1'b1, z: 1'b0};
    vecs[5] = '{a: 4'd8,  b: 4'd8, m: 1'b0, s: 4'd0,  c: 1'b1, v: 1'b1, z: 1'b1};
    vecs[6] = '{a: 4'd0,  b: 4'd8, m: 1'b1, s: 4'd8,  c: 1'b0, v: 1'b1, z: 1'b0};
`endif

    bus4.start = 1'b0; bus4.A = '0; bus4.B = '0; bus4.M = 1'b0;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.M = 1'b0;

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy4", bus4.busy, 0);
    check("rst_done4", bus4.done, 0);
    check("rst_S4", bus4.S, 0);
    check("rst_C4", bus4.C, 0);
    check("rst_V4", bus4.V, 0);
    check("rst_Z4", bus4.Z, 0);
    check("rst_busy8", bus8.busy, 0);
    check("rst_S8", bus8.S, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table on the 4-bit, one-bit-per-cycle instance.
    for (int i = 0; i < 7; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].m, s4, c, v, z);
      check($sformatf("vec%0d_S", i), s4, vecs[i].s);
      check($sformatf("vec%0d_C", i), c, vecs[i].c);
      check($sformatf("vec%0d_V", i), v, vecs[i].v);
      check($sformatf("vec%0d_Z", i), z, vecs[i].z);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_one_cycle", i), bus4.done, 0);
    end

    // Two-bit digits: 200 + 100.
    op8(8'd200, 8'd100, 1'b0, s8, c, v, z);
    check("w8_S", s8, 44);
    check("w8_C", c, 1);
    check("w8_V", v, 0);
    check("w8_Z", z, 0);

    // Back-to-back: start issued in the done cycle.
    op8(8'd10, 8'd30, 1'b1, s8, c, v, z);
    check("b2b_S", s8, 236);
    check("b2b_C", c, 0);
    check("b2b_V", v, 0);

    // Start pulsed at edge 2 with different operands must be ignored.
    @(posedge clk); #1;
    bus8.A = 8'd50; bus8.B = 8'd25; bus8.M = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus8.A = 8'd1; bus8.B = 8'd1; bus8.M = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    check("ign_no_early_done", bus8.done, 0);
    @(posedge clk); #1;
    check("ign_done", bus8.done, 1);
    check("ign_S", bus8.S, 75);
    @(posedge clk); #1;
    check("ign_not_restarted", bus8.busy, 0);
    check("ign_done_dropped", bus8.done, 0);

    // Random operands on the 8-bit instance, back-to-back.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
      op8(ra, rb, rm, s8, c, v, z);
      model(8, longint'(ra), longint'(rb), rm, es, ec, ev, ez);
      check("rnd8_S", s8, es);
      check("rnd8_C", c, ec);
      check("rnd8_V", v, ev);
      check("rnd8_Z", z, ez);
    end

    // Random operands on the 4-bit instance.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15)); rm = 1'($urandom);
      op4(ra[3:0], rb[3:0], rm, s4, c, v, z);
      model(4, longint'(ra), longint'(rb), rm, es, ec, ev, ez);
      check("rnd4_S", s4, es);
      check("rnd4_C", c, ec);
      check("rnd4_V", v, ev);
      check("rnd4_Z", z, ez);
    end

    // Asynchronous reset at edge 2 of an operation.
    op4(4'd3, 4'd2, 1'b0, s4, c, v, z);
    bus4.A = 4'd5; bus4.B = 4'd6; bus4.M = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus4.busy, 0);
    check("arst_S", bus4.S, 0);
    check("arst_done", bus4.done, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      check("arst_no_done", bus4.done, 0);
    end
    op4(4'd5, 4'd6, 1'b0, s4, c, v, z);
    check("arst_after_S", s4, 11);
    check("arst_after_V", v, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
